// File: rtl/fp_op_sched.sv
// fp_op_sched: round-robin scheduler that feeds several requesters into one
// shared mul/add unit pair and returns tagged results through an in-order FIFO.
// Optional statistics counters are built when FP_OP_SCHED_STATS_EN is defined.
//
// Handshakes: a transfer happens on a channel in any cycle where valid and
// ready are both high at the rising edge; valid never depends on ready.
module fp_op_sched #(
    parameter int SIGN_W     = 1,
    parameter int EXPO_W     = 8,
    parameter int MANT_W     = 23,
    parameter int NUM_REQ    = 2,
    parameter int LAT        = 2,
    parameter int RESP_DEPTH = 4,
    localparam int W         = SIGN_W + EXPO_W + MANT_W,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_op,
    input  logic [NUM_REQ*W-1:0]   req_a,
    input  logic [NUM_REQ*W-1:0]   req_b,
    input  logic [NUM_REQ*2-1:0]   req_rnd,
    output logic                   fu_valid,
    output logic                   fu_op,
    output logic [W-1:0]           fu_a,
    output logic [W-1:0]           fu_b,
    output logic [1:0]             fu_rnd,
    input  logic [W-1:0]           fu_res_mul,
    input  logic [W-1:0]           fu_res_add,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [W-1:0]           rsp_res,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_op
`ifdef FP_OP_SCHED_STATS_EN
    ,
    output logic [31:0]            stat_issue,
    output logic [31:0]            stat_stall
`endif
);

    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam int E_W   = W + ID_W + 1;

    // Round-robin candidate: requester k places after the pointer, wrapping.
    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % NUM_REQ;
        return ID_W'(s);
    endfunction

    logic [ID_W-1:0]  p_q, p_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic             fu_valid_q, fu_valid_d;
    logic             fu_op_q, fu_op_d;
    logic [W-1:0]     fu_a_q, fu_a_d;
    logic [W-1:0]     fu_b_q, fu_b_d;
    logic [1:0]       fu_rnd_q, fu_rnd_d;
    logic [ID_W-1:0]  fu_id_q, fu_id_d;
    logic [LAT-1:0]   tv_q, tv_d;
    logic [LAT-1:0]   top_q, top_d;
    logic [ID_W-1:0]  tid_q [LAT];
    logic [ID_W-1:0]  tid_d [LAT];
    logic [E_W-1:0]   mem_q [RESP_DEPTH];
    logic [E_W-1:0]   mem_d [RESP_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             gnt_found;
    logic [ID_W-1:0]  gnt_idx;
    logic             accept;
    logic             push;
    logic             pop;
    logic [E_W-1:0]   push_data;
    logic             sel_op;
    logic [W-1:0]     sel_a;
    logic [W-1:0]     sel_b;
    logic [1:0]       sel_rnd;

    // Grant search and operand mux for the granted requester.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sel_op    = 1'b0;
        sel_a     = '0;
        sel_b     = '0;
        sel_rnd   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_found && req_valid[rr_idx(p_q, k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = rr_idx(p_q, k);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                sel_op  = req_op[i];
                sel_a   = req_a[i*W +: W];
                sel_b   = req_b[i*W +: W];
                sel_rnd = req_rnd[i*2 +: 2];
            end
        end
    end

    // Ready is only offered while a FIFO slot is reserved for the result.
    always_comb begin
        accept    = gnt_found && (out_q < CNT_W'(RESP_DEPTH)) && !rst;
        req_ready = '0;
        if (accept) req_ready[gnt_idx] = 1'b1;
        rsp_valid = (cnt_q != '0) && !rst;
        pop       = rsp_valid && rsp_ready;
        push      = tv_q[LAT-1];
        push_data = {(top_q[LAT-1] ? fu_res_add : fu_res_mul), tid_q[LAT-1], top_q[LAT-1]};
        if (cnt_q != '0) begin
            {rsp_res, rsp_id, rsp_op} = mem_q[rd_q];
        end else begin
            {rsp_res, rsp_id, rsp_op} = '0;
        end
    end

    // Next state: pointer, outstanding count, issue registers, tag pipe, FIFO.
    always_comb begin
        p_d        = p_q;
        out_d      = out_q;
        fu_valid_d = accept;
        fu_op_d    = fu_op_q;
        fu_a_d     = fu_a_q;
        fu_b_d     = fu_b_q;
        fu_rnd_d   = fu_rnd_q;
        fu_id_d    = fu_id_q;
        tv_d       = tv_q;
        top_d      = top_q;
        tid_d      = tid_q;
        mem_d      = mem_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;

        if (accept) begin
            p_d      = rr_idx(gnt_idx, 1);
            fu_op_d  = sel_op;
            fu_a_d   = sel_a;
            fu_b_d   = sel_b;
            fu_rnd_d = sel_rnd;
            fu_id_d  = gnt_idx;
        end
        if (accept && !pop) out_d = out_q + CNT_W'(1);
        if (!accept && pop) out_d = out_q - CNT_W'(1);

        // Tag stage k holds the issue made k+1 cycles before fu_valid.
        tv_d[0]  = fu_valid_q;
        top_d[0] = fu_op_q;
        tid_d[0] = fu_id_q;
        for (int k = 1; k < LAT; k++) begin
            tv_d[k]  = tv_q[k-1];
            top_d[k] = top_q[k-1];
            tid_d[k] = tid_q[k-1];
        end

        if (push) begin
            mem_d[wr_q] = push_data;
            wr_d = (wr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_d = (rd_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
        end
        if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
        if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
    end

    // State registers; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q        <= '0;
            out_q      <= '0;
            fu_valid_q <= 1'b0;
            fu_op_q    <= 1'b0;
            fu_a_q     <= '0;
            fu_b_q     <= '0;
            fu_rnd_q   <= '0;
            fu_id_q    <= '0;
            tv_q       <= '0;
            top_q      <= '0;
            for (int k = 0; k < LAT; k++) tid_q[k] <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
        end else begin
            p_q        <= p_d;
            out_q      <= out_d;
            fu_valid_q <= fu_valid_d;
            fu_op_q    <= fu_op_d;
            fu_a_q     <= fu_a_d;
            fu_b_q     <= fu_b_d;
            fu_rnd_q   <= fu_rnd_d;
            fu_id_q    <= fu_id_d;
            tv_q       <= tv_d;
            top_q      <= top_d;
            tid_q      <= tid_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
        end
    end

    // FIFO storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign fu_valid = fu_valid_q;
    assign fu_op    = fu_op_q;
    assign fu_a     = fu_a_q;
    assign fu_b     = fu_b_q;
    assign fu_rnd   = fu_rnd_q;

`ifdef FP_OP_SCHED_STATS_EN
    logic [31:0] stat_issue_q, stat_issue_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Wrapping counters of accepts and of cycles with demand but no accept.
    always_comb begin
        stat_issue_d = stat_issue_q + {31'b0, accept};
        stat_stall_d = stat_stall_q + {31'b0, ((|req_valid) && !accept)};
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issue_q <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_issue_q <= stat_issue_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_issue = stat_issue_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_fp_op_sched.sv
// Bench for fp_op_sched: directed scenarios plus random traffic, checked
// against a transaction-level model (grant rotation, outstanding budget,
// in-order expected-response queue with ready-cycle stamps).
module tb_fp_op_sched;

    localparam int NUM_REQ    = 2;
    localparam int LAT        = 2;
    localparam int RESP_DEPTH = 4;
    localparam int W          = 32;
    localparam int ID_W       = 1;
    localparam int E_W        = W + ID_W + 1;

    logic                 clk;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   req_op;
    logic [NUM_REQ*W-1:0] req_a;
    logic [NUM_REQ*W-1:0] req_b;
    logic [NUM_REQ*2-1:0] req_rnd;
    logic                 fu_valid;
    logic                 fu_op;
    logic [W-1:0]         fu_a;
    logic [W-1:0]         fu_b;
    logic [1:0]           fu_rnd;
    logic [W-1:0]         fu_res_mul;
    logic [W-1:0]         fu_res_add;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [W-1:0]         rsp_res;
    logic [ID_W-1:0]      rsp_id;
    logic                 rsp_op;
`ifdef FP_OP_SCHED_STATS_EN
    logic [31:0]          stat_issue;
    logic [31:0]          stat_stall;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    fp_op_sched #(
        .SIGN_W(1), .EXPO_W(8), .MANT_W(23),
        .NUM_REQ(NUM_REQ), .LAT(LAT), .RESP_DEPTH(RESP_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_rnd(req_rnd),
        .fu_valid(fu_valid), .fu_op(fu_op), .fu_a(fu_a), .fu_b(fu_b), .fu_rnd(fu_rnd),
        .fu_res_mul(fu_res_mul), .fu_res_add(fu_res_add),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_id(rsp_id), .rsp_op(rsp_op)
`ifdef FP_OP_SCHED_STATS_EN
        , .stat_issue(stat_issue), .stat_stall(stat_stall)
`endif
    );

    // ---------------- clock / cycle counter ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- shared unit model ----------------
    // Fixed IEEE cases for the directed tests, otherwise an arbitrary but
    // distinct function per op so a wrong-unit selection is visible.
    function automatic logic [W-1:0] unit_res(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return op ? 32'h40400000 : 32'h40000000;
        return op ? (a + b) : (a ^ {b[15:0], b[31:16]});
    endfunction

    logic [W-1:0] pm [LAT];
    logic [W-1:0] pa [LAT];

    always @(posedge clk) begin
        pm[0] <= fu_valid ? unit_res(1'b0, fu_a, fu_b) : W'($urandom);
        pa[0] <= fu_valid ? unit_res(1'b1, fu_a, fu_b) : W'($urandom);
        for (int k = 1; k < LAT; k++) begin
            pm[k] <= pm[k-1];
            pa[k] <= pa[k-1];
        end
    end

    assign fu_res_mul = pm[LAT-1];
    assign fu_res_add = pa[LAT-1];

    // ---------------- reference model / scoreboard ----------------
    int                 m_p;
    int                 m_out;
    logic [E_W-1:0]     exp_q[$];
    int                 avail_q[$];
    logic [NUM_REQ-1:0] acc_mask;
    logic [NUM_REQ-1:0] m_rdy;
    logic               m_rv;
    int                 gi;
    bit                 live = 1'b0;
    logic               fe_v;
    logic               fe_op;
    logic [W-1:0]       fe_a;
    logic [W-1:0]       fe_b;
    logic [1:0]         fe_rnd;

    always @(negedge clk) begin
        m_rdy = '0;
        gi = -1;
        if (!rst) begin
            for (int k = 0; k < NUM_REQ; k++)
                if (gi < 0 && req_valid[(m_p + k) % NUM_REQ]) gi = (m_p + k) % NUM_REQ;
            if (gi >= 0 && m_out < RESP_DEPTH) m_rdy[gi] = 1'b1;
        end
        m_rv = !rst && (exp_q.size() > 0) && (avail_q[0] <= cyc);

        if (live) begin
            checks++;
            if (req_ready !== m_rdy) begin
                errors++;
                $display("FAIL req_ready cyc=%0d: got %b expected %b", cyc, req_ready, m_rdy);
            end
            checks++;
            if (rsp_valid !== m_rv) begin
                errors++;
                $display("FAIL rsp_valid cyc=%0d: got %b expected %b", cyc, rsp_valid, m_rv);
            end
            if (m_rv) begin
                checks++;
                if ({rsp_res, rsp_id, rsp_op} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rsp_data cyc=%0d: got %h/%0d/%0d expected %h", cyc, rsp_res, rsp_id, rsp_op, exp_q[0]);
                end
            end else if (!rst) begin
                checks++;
                if ({rsp_res, rsp_id, rsp_op} !== '0) begin
                    errors++;
                    $display("FAIL rsp_idle cyc=%0d: got %h/%0d/%0d expected 0", cyc, rsp_res, rsp_id, rsp_op);
                end
            end
            checks++;
            if (fu_valid !== fe_v) begin
                errors++;
                $display("FAIL fu_valid cyc=%0d: got %b expected %b", cyc, fu_valid, fe_v);
            end
            checks++;
            if ({fu_op, fu_a, fu_b, fu_rnd} !== {fe_op, fe_a, fe_b, fe_rnd}) begin
                errors++;
                $display("FAIL fu_fields cyc=%0d: got %0d %h %h %0d expected %0d %h %h %0d",
                         cyc, fu_op, fu_a, fu_b, fu_rnd, fe_op, fe_a, fe_b, fe_rnd);
            end
        end

        if (rst) begin
            m_p = 0;
            m_out = 0;
            exp_q.delete();
            avail_q.delete();
            acc_mask = '0;
            fe_v = 1'b0;
            fe_op = 1'b0;
            fe_a = '0;
            fe_b = '0;
            fe_rnd = '0;
            live = 1'b1;
        end else begin
            acc_mask = m_rdy & req_valid;
            if (m_rv && rsp_ready) begin
                void'(exp_q.pop_front());
                void'(avail_q.pop_front());
                m_out--;
            end
            fe_v = 1'b0;
            if (acc_mask != '0) begin
                fe_v   = 1'b1;
                fe_op  = req_op[gi];
                fe_a   = req_a[gi*W +: W];
                fe_b   = req_b[gi*W +: W];
                fe_rnd = req_rnd[gi*2 +: 2];
                exp_q.push_back({unit_res(fe_op, fe_a, fe_b), ID_W'(gi), fe_op});
                avail_q.push_back(cyc + LAT + 2);
                m_p = (gi + 1) % NUM_REQ;
                m_out++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_req(input int i, input logic op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [1:0] rnd);
        req_op[i] = op;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_rnd[i*2 +: 2] = rnd;
    endtask

    task automatic load_rand(input int i);
        load_req(i, 1'($urandom_range(1)), W'($urandom), W'($urandom), 2'($urandom_range(3)));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (LAT + RESP_DEPTH + 6) step();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        load_req(0, 1'b1, 32'h12345678, 32'h9ABCDEF0, 2'd3);
        load_req(1, 1'b0, 32'h0F0F0F0F, 32'hF0F0F0F0, 2'd2);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (req_ready !== '0) begin
                errors++;
                $display("FAIL reset_ready: got %b expected 0", req_ready);
            end
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
            end
            step();
        end
        @(negedge clk);
        checks++;
        if ({fu_valid, fu_op, fu_a, fu_b, fu_rnd} !== '0) begin
            errors++;
            $display("FAIL reset_fu: got %b %b %h %h %0d expected all 0", fu_valid, fu_op, fu_a, fu_b, fu_rnd);
        end
        checks++;
        if ({rsp_res, rsp_id, rsp_op} !== '0) begin
            errors++;
            $display("FAIL reset_rsp_fields: got %h/%0d/%0d expected 0", rsp_res, rsp_id, rsp_op);
        end
        step();
        req_valid = '0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_mul();
        int t0;
        int got;
        do_reset();
        rsp_ready = 1'b1;
        load_req(0, 1'b0, 32'h3F800000, 32'h40000000, 2'd0);
        req_valid = 2'b01;
        @(negedge clk);
        t0 = cyc;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_accept: got %b expected 01", req_ready);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (fu_valid !== 1'b1 || fu_a !== 32'h3F800000 || fu_b !== 32'h40000000 || fu_op !== 1'b0) begin
            errors++;
            $display("FAIL single_issue: got v=%b op=%b %h %h expected 1 0 3f800000 40000000", fu_valid, fu_op, fu_a, fu_b);
        end
        got = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = cyc;
                break;
            end
        end
        checks++;
        if (got !== t0 + LAT + 2) begin
            errors++;
            $display("FAIL single_latency: got cycle %0d expected %0d", got, t0 + LAT + 2);
        end
        checks++;
        if (rsp_res !== 32'h40000000 || rsp_id !== 1'b0 || rsp_op !== 1'b0) begin
            errors++;
            $display("FAIL single_result: got %h/%0d/%0d expected 40000000/0/0", rsp_res, rsp_id, rsp_op);
        end
        step();
        drain();
    endtask

    task automatic test_alternate();
        int n_acc;
        int n_rsp;
        do_reset();
        rsp_ready = 1'b1;
        load_req(0, 1'b1, 32'h3F800000, 32'h40000000, 2'd1);
        load_req(1, 1'b1, 32'h3F800000, 32'h40000000, 2'd1);
        req_valid = 2'b11;
        n_acc = 0;
        n_rsp = 0;
        for (int k = 0; k < 80 && (n_acc < 8 || n_rsp < 8); k++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != '0) begin
                checks++;
                if (int'(req_ready[1]) !== n_acc % 2) begin
                    errors++;
                    $display("FAIL alt_grant: got %b expected requester %0d", req_ready, n_acc % 2);
                end
                n_acc++;
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (rsp_res !== 32'h40400000 || int'(rsp_id) !== n_rsp % 2) begin
                    errors++;
                    $display("FAIL alt_rsp: got %h id %0d expected 40400000 id %0d", rsp_res, rsp_id, n_rsp % 2);
                end
                n_rsp++;
            end
            step();
            if (n_acc >= 8) req_valid = '0;
        end
        checks++;
        if (n_acc !== 8 || n_rsp !== 8) begin
            errors++;
            $display("FAIL alt_counts: got %0d accepts %0d responses expected 8 8", n_acc, n_rsp);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int left [NUM_REQ];
        int n_acc;
        int n_rsp;
        do_reset();
        rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            left[i] = 3;
            load_rand(i);
        end
        req_valid = '1;
        n_acc = 0;
        n_rsp = 0;
        for (int c = 0; c < 120 && (n_acc < 6 || n_rsp < 6); c++) begin
            if (c == 20) begin
                checks++;
                if (n_acc !== RESP_DEPTH) begin
                    errors++;
                    $display("FAIL bp_accepts: got %0d expected %0d", n_acc, RESP_DEPTH);
                end
                rsp_ready = 1'b1;
            end
            @(negedge clk);
            if (c == 19) begin
                checks++;
                if (req_ready !== '0) begin
                    errors++;
                    $display("FAIL bp_ready_low: got %b expected 0", req_ready);
                end
            end
            if ((req_valid & req_ready) != '0) n_acc++;
            if (rsp_valid && rsp_ready) n_rsp++;
            step();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc_mask[i]) begin
                    left[i]--;
                    if (left[i] > 0) load_rand(i);
                    else req_valid[i] = 1'b0;
                end
            end
        end
        checks++;
        if (n_acc !== 6 || n_rsp !== 6) begin
            errors++;
            $display("FAIL bp_totals: got %0d accepts %0d responses expected 6 6", n_acc, n_rsp);
        end
        drain();
    endtask

    task automatic test_reset_inflight();
        int n_acc;
        do_reset();
        rsp_ready = 1'b1;
        load_req(0, 1'b0, 32'h3F800000, 32'h40000000, 2'd0);
        req_valid = 2'b01;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 2'b01) begin
                errors++;
                $display("FAIL inflight_accept: got %b expected 01", req_ready);
            end
            step();
            load_rand(0);
        end
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL inflight_discard: got rsp_valid %b expected 0", rsp_valid);
            end
            step();
        end
        rsp_ready = 1'b0;
        load_rand(0);
        load_rand(1);
        req_valid = 2'b11;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL inflight_next_grant: got %b expected 01", req_ready);
        end
        step();
        req_valid = 2'b01;
        n_acc = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != '0) n_acc++;
            step();
            load_rand(0);
        end
        checks++;
        if (n_acc !== RESP_DEPTH) begin
            errors++;
            $display("FAIL inflight_outstanding: got %0d accepts expected %0d", n_acc, RESP_DEPTH);
        end
        drain();
    endtask

    task automatic test_pop_accept();
        int n_acc;
        do_reset();
        rsp_ready = 1'b0;
        load_rand(0);
        req_valid = 2'b01;
        step();
        load_rand(0);
        step();
        req_valid = '0;
        repeat (LAT + 4) step();
        load_rand(0);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || req_ready !== 2'b01) begin
            errors++;
            $display("FAIL pop_accept_same: got rsp_valid %b req_ready %b expected 1 01", rsp_valid, req_ready);
        end
        step();
        rsp_ready = 1'b0;
        load_rand(0);
        n_acc = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != '0) n_acc++;
            step();
            load_rand(0);
        end
        checks++;
        if (n_acc !== RESP_DEPTH - 2) begin
            errors++;
            $display("FAIL pop_accept_outstanding: got %0d extra accepts expected %0d", n_acc, RESP_DEPTH - 2);
        end
        drain();
    endtask

    task automatic test_random();
        int n_rsp;
        do_reset();
        n_rsp = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc_mask[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(99) < 60) begin
                    load_rand(i);
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = ($urandom_range(99) < ((c < 200) ? 35 : 85));
            @(negedge clk);
            if (rsp_valid && rsp_ready) n_rsp++;
            step();
        end
        drain();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || n_rsp == 0) begin
            errors++;
            $display("FAIL random_drain: got rsp_valid %b after %0d responses expected 0 after >0", rsp_valid, n_rsp);
        end
        step();
    endtask

`ifdef FP_OP_SCHED_STATS_EN
    task automatic test_stats();
        int n_acc;
        do_reset();
        @(negedge clk);
        checks++;
        if (stat_issue !== 32'd0 || stat_stall !== 32'd0) begin
            errors++;
            $display("FAIL stats_reset: got %0d %0d expected 0 0", stat_issue, stat_stall);
        end
        step();
        rsp_ready = 1'b0;
        load_rand(0);
        req_valid = 2'b01;
        repeat (RESP_DEPTH + 3) begin
            step();
            load_rand(0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (10) step();
        n_acc = 0;
        repeat (10 - RESP_DEPTH) begin
            load_rand(0);
            req_valid = 2'b01;
            @(negedge clk);
            if (req_ready == 2'b01) n_acc++;
            step();
            req_valid = '0;
            step();
        end
        @(negedge clk);
        checks++;
        if (n_acc !== 10 - RESP_DEPTH) begin
            errors++;
            $display("FAIL stats_spaced_accepts: got %0d expected %0d", n_acc, 10 - RESP_DEPTH);
        end
        checks++;
        if (stat_issue !== 32'd10) begin
            errors++;
            $display("FAIL stats_issue: got %0d expected 10", stat_issue);
        end
        checks++;
        if (stat_stall !== 32'd3) begin
            errors++;
            $display("FAIL stats_stall: got %0d expected 3", stat_stall);
        end
        step();
        drain();
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        req_rnd = '0;
        test_reset();
        test_single_mul();
        test_alternate();
        test_backpressure();
        test_reset_inflight();
        test_pop_accept();
        test_random();
`ifdef FP_OP_SCHED_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
